// File: rtl/img_frame_ctrl_if.sv
// Control/status bundle between the image frame controller and its environment.
// The slave modport is the controller side; the master modport drives the stimulus.
interface img_frame_ctrl_if;
    logic [2:0] BOTON_SEL;
    logic       frame_req;
    logic       HSYNC;
    logic       ctrl_done;
    logic       proc_rst_n;
    logic [1:0] op_sel;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [9:0] line_cnt;
    logic [7:0] frame_cnt;

    modport master (
        output BOTON_SEL, frame_req, HSYNC, ctrl_done,
        input  proc_rst_n, op_sel, busy, frame_ok, frame_err, line_cnt, frame_cnt
    );

    modport slave (
        input  BOTON_SEL, frame_req, HSYNC, ctrl_done,
        output proc_rst_n, op_sel, busy, frame_ok, frame_err, line_cnt, frame_cnt
    );
endinterface

// File: rtl/img_frame_ctrl.sv
// Frame-level sequencer for the image datapath: debounced operation buttons,
// datapath restart pulse, line counting, watchdog and per-frame status.
module img_frame_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned RST_HOLD        = 4,
    parameter int unsigned LINES           = 250,
    parameter int unsigned TIMEOUT         = 2000000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    img_frame_ctrl_if.slave   bus
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_PRE    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT);
    localparam logic [9:0]        LINES_C   = 10'(LINES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q [3];
    logic [DB_W-1:0]   db_cnt_d [3];
    logic              hsync_q, hsync_d;
    logic [1:0]        pending_op_q, pending_op_d;
    logic [1:0]        op_sel_q, op_sel_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              proc_rst_n_q, proc_rst_n_d;
    logic              busy_q, busy_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [9:0]        line_cnt_q, line_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic [2:0]        press;
    logic              any_press;
    logic [1:0]        press_op;
    logic              hs_rise;

    always_comb begin
        sync1_d = bus.BOTON_SEL;
        sync2_d = sync1_q;
        press   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!sync2_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] != DB_MAX) begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end else begin
                db_cnt_d[i] = db_cnt_q[i];
            end
            // Fires only on the step into DB_MAX; a saturated counter stays silent.
            press[i] = sync2_q[i] && (db_cnt_q[i] == DB_PRE);
        end

        any_press = |press;
        if (press[0]) begin
            press_op = 2'b01;
        end else if (press[1]) begin
            press_op = 2'b10;
        end else begin
            press_op = 2'b11;
        end
        pending_op_d = any_press ? press_op : pending_op_q;

        hsync_d = bus.HSYNC;
        hs_rise = bus.HSYNC && !hsync_q;

        state_d      = state_q;
        op_sel_d     = op_sel_q;
        hold_cnt_d   = hold_cnt_q;
        wd_d         = wd_q;
        line_cnt_d   = line_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        proc_rst_n_d = 1'b1;
        busy_d       = 1'b0;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.frame_req || any_press) begin
                    state_d      = ARM;
                    op_sel_d     = pending_op_d;
                    line_cnt_d   = '0;
                    hold_cnt_d   = '0;
                    proc_rst_n_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ARM: begin
                busy_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    wd_d    = WD_W'(1);
                end else begin
                    hold_cnt_d   = hold_cnt_q + 1'b1;
                    proc_rst_n_d = 1'b0;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                wd_d   = wd_q + 1'b1;
                if (hs_rise && (line_cnt_q != '1)) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                // Status is resolved here so it appears as a registered pulse in DONE;
                // the line check uses the post-increment count.
                if (bus.ctrl_done) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    wd_d    = '0;
                    if (line_cnt_d == LINES_C) begin
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (wd_q == WD_MAX) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    wd_d        = '0;
                    frame_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            hsync_q      <= 1'b0;
            pending_op_q <= '0;
            op_sel_q     <= '0;
            hold_cnt_q   <= '0;
            wd_q         <= '0;
            proc_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            line_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            hsync_q      <= hsync_d;
            pending_op_q <= pending_op_d;
            op_sel_q     <= op_sel_d;
            hold_cnt_q   <= hold_cnt_d;
            wd_q         <= wd_d;
            proc_rst_n_q <= proc_rst_n_d;
            busy_q       <= busy_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            line_cnt_q   <= line_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.proc_rst_n = proc_rst_n_q;
    assign bus.op_sel     = op_sel_q;
    assign bus.busy       = busy_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.line_cnt   = line_cnt_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule
